// File: rtl/alu_adder_pipe_if.sv
// Operand/result handshake bundle for alu_adder_pipe.
// The master drives operands and accepts results. The slave is the adder unit.
interface alu_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, op, cin, sat, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, op, cin, sat, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/alu_adder_pipe.sv
// Pipelined add/subtract unit. The carry ripples through one CHUNK-bit slice per stage.
// The last stage resolves signed saturation and the flags behind a valid/ready handshake.
module alu_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_adder_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK != 0) || (STAGES < 1)) begin : g_param_check
        $error("alu_adder_pipe: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;    // effective B, already inverted for SUB/SBB
        logic [WIDTH-1:0] s;    // partial sum, meaningful below the current slice
        logic             c;
        logic             sat;
    } stage_t;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    stage_t           stg_in [STAGES];
    logic             vld_in [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;

    // The whole pipe freezes as one when the result is waiting, bubbles included.
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // ADD and SUB force the carry-in to 0 and 1. ADC and SBB take cin.
    assign b_eff     = bus.op[0] ? ~bus.b : bus.b;
    assign c0        = bus.op[1] ? bus.cin : bus.op[0];
    assign stg_in[0] = {bus.a, b_eff, {WIDTH{1'b0}}, c0, bus.sat};
    assign vld_in[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0] slice_sum;
        stage_t         stage_d;

        assign slice_sum = {1'b0, stg_in[k].a[k*CHUNK +: CHUNK]}
                         + {1'b0, stg_in[k].b[k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, stg_in[k].c};

        // NOTE: every field gets its default first, so no path through the block can infer a latch.
        always_comb begin
            stage_d                     = stg_in[k];
            stage_d.s[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
            stage_d.c                   = slice_sum[CHUNK];
        end

        if (k < STAGES - 1) begin : g_mid
            stage_t data_q;
            logic   valid_q;

            // NOTE: sequential state uses non-blocking assignments, so every stage samples pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= vld_in[k];
                end
            end

            // NOTE: datapath registers have no reset. valid_q qualifies them, and it is reset.
            always_ff @(posedge clk) begin
                if (advance && vld_in[k]) begin
                    data_q <= stage_d;
                end
            end

            assign stg_in[k+1] = data_q;
            assign vld_in[k+1] = valid_q;
        end else begin : g_last
            logic [WIDTH-1:0] raw;
            logic [WIDTH-1:0] res;
            logic             a_msb;
            logic             ovf;

            assign raw   = stage_d.s;
            assign a_msb = stg_in[k].a[WIDTH-1];
            assign ovf   = (a_msb == stg_in[k].b[WIDTH-1]) && (raw[WIDTH-1] != a_msb);
            // Clamp toward the sign of A: most negative value if A < 0, most positive otherwise.
            assign res   = (stg_in[k].sat && ovf) ? {a_msb, {(WIDTH-1){!a_msb}}} : raw;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    carry_q     <= 1'b0;
                    overflow_q  <= 1'b0;
                    zero_q      <= 1'b0;
                    negative_q  <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= vld_in[k];
                    if (vld_in[k]) begin
                        sum_q      <= res;
                        carry_q    <= stage_d.c;
                        overflow_q <= ovf;
                        zero_q     <= (res == '0);
                        negative_q <= res[WIDTH-1];
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
endmodule

// File: tb/tb_alu_adder_pipe.sv
// Directed bench for alu_adder_pipe at WIDTH/CHUNK = 16/4, 32/8 and 64/16.
// The vectors are hand-computed. Every comparison is an immediate assertion.
module tb_alu_adder_pipe;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11;
    localparam int LAT = 3;  // edges after the accept edge until out_valid is seen

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_adder_pipe_if #(.WIDTH(16)) if16 ();
    alu_adder_pipe_if #(.WIDTH(32)) if32 ();
    alu_adder_pipe_if #(.WIDTH(64)) if64 ();

    alu_adder_pipe #(.WIDTH(16), .CHUNK(4))  dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    alu_adder_pipe #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    alu_adder_pipe #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sel: 0 -> 16-bit unit, 1 -> 32-bit unit, 2 -> 64-bit unit
    task automatic drive(input int sel, input logic v, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sat);
        case (sel)
            0: begin
                if16.in_valid = v; if16.op = op; if16.cin = cin; if16.sat = sat;
                if16.a = a[15:0]; if16.b = b[15:0];
            end
            1: begin
                if32.in_valid = v; if32.op = op; if32.cin = cin; if32.sat = sat;
                if32.a = a[31:0]; if32.b = b[31:0];
            end
            default: begin
                if64.in_valid = v; if64.op = op; if64.cin = cin; if64.sat = sat;
                if64.a = a; if64.b = b;
            end
        endcase
    endtask

    task automatic sample(input int sel, output logic ov, output logic [63:0] s,
                          output logic co, output logic of, output logic z, output logic n);
        s = '0;
        case (sel)
            0: begin
                ov = if16.out_valid; s[15:0] = if16.sum; co = if16.carry_out;
                of = if16.overflow; z = if16.zero; n = if16.negative;
            end
            1: begin
                ov = if32.out_valid; s[31:0] = if32.sum; co = if32.carry_out;
                of = if32.overflow; z = if32.zero; n = if32.negative;
            end
            default: begin
                ov = if64.out_valid; s = if64.sum; co = if64.carry_out;
                of = if64.overflow; z = if64.zero; n = if64.negative;
            end
        endcase
    endtask

    // Called between edges. The task issues one beat, waits a bounded time for its result,
    // checks the result and returns just after a falling edge with the pipe empty.
    task automatic run_op(input int sel, input string name, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sat,
                          input logic [63:0] e_sum, input logic e_co, input logic e_of,
                          input logic e_z, input logic e_n);
        logic        ov, co, of, z, n;
        logic [63:0] s;
        int          lat;
        string       tag;
        tag = $sformatf("w%0d_%s", 16 << sel, name);
        drive(sel, 1'b1, op, a, b, cin, sat);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, op, a, b, cin, sat);
        lat = 0;
        sample(sel, ov, s, co, of, z, n);
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
            sample(sel, ov, s, co, of, z, n);
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_sum"}, s, e_sum);
        check({tag, "_carry"}, {63'b0, co}, {63'b0, e_co});
        check({tag, "_ovf"}, {63'b0, of}, {63'b0, e_of});
        check({tag, "_zero"}, {63'b0, z}, {63'b0, e_z});
        check({tag, "_neg"}, {63'b0, n}, {63'b0, e_n});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] mask, msb, maxpos, held;
        int          w, sent, got, stale;

        if16.out_ready = 1'b1; if32.out_ready = 1'b1; if64.out_ready = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, ADD, '0, '0, 1'b0, 1'b0);

        // Reset state, sampled while reset is asserted
        #12;
        check("rst_out_valid", {63'b0, if32.out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, if32.in_ready}, 64'd1);
        check("rst_sum", {32'b0, if32.sum}, 64'd0);
        check("rst_flags", {60'b0, if32.carry_out, if32.overflow, if32.zero, if32.negative}, 64'd0);
        check("rst_out_valid_w16", {63'b0, if16.out_valid}, 64'd0);
        check("rst_out_valid_w64", {63'b0, if64.out_valid}, 64'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);

        // Vectors 1-3 at each width, plus cin being ignored by ADD/SUB
        for (int s = 0; s < 3; s++) begin
            w      = 16 << s;
            mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
            msb    = 64'd1 << (w - 1);
            maxpos = mask >> 1;
            run_op(s, "add_wrap", ADD, mask, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            run_op(s, "sub_neg", SUB, 64'd5, 64'd7, 1'b0, 1'b0, mask - 64'd1, 1'b0, 1'b0, 1'b0, 1'b1);
            run_op(s, "sub_eq", SUB, 64'd7, 64'd7, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            run_op(s, "add_ovf", ADD, maxpos, 64'd1, 1'b0, 1'b0, msb, 1'b0, 1'b1, 1'b0, 1'b1);
            run_op(s, "add_sat", ADD, maxpos, 64'd1, 1'b0, 1'b1, maxpos, 1'b0, 1'b1, 1'b0, 1'b0);
            run_op(s, "sub_sat", SUB, msb, 64'd1, 1'b0, 1'b1, msb, 1'b1, 1'b1, 1'b0, 1'b1);
            run_op(s, "add_cin_ign", ADD, 64'd3, 64'd4, 1'b1, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 64-bit chain built from 32-bit ADC/SBB beats
        run_op(1, "adc_lo", ADC, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(1, "adc_hi", ADC, 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1, "sbb_borrow", SBB, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(1, "sbb_noborrow", SBB, 64'd9, 64'd4, 1'b1, 1'b0, 64'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back ADDs, consumer stalls in cycles 5..7
        sent = 0; got = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if32.out_ready = !(cyc >= 5 && cyc <= 7);
            drive(1, sent < 8, ADD, 64'(sent), 64'd100, 1'b0, 1'b0);
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check($sformatf("stall_in_ready_c%0d", cyc), {63'b0, if32.in_ready}, 64'd0);
                if (cyc == 5) held = {32'b0, if32.sum};
                else check($sformatf("stall_sum_hold_c%0d", cyc), {32'b0, if32.sum}, held);
            end
            if (if32.out_valid && if32.out_ready) begin
                check($sformatf("stream_result_%0d", got), {32'b0, if32.sum}, 64'(100 + got));
                got++;
            end
            if (if32.in_valid && if32.in_ready) sent++;
            @(negedge clk);
        end
        check("stream_count", 64'(got), 64'd8);
        drive(1, 1'b0, ADD, '0, '0, 1'b0, 1'b0);
        if32.out_ready = 1'b1;

        // Reset mid-flight: three beats inside the 32-bit pipe, the first one at the output
        drive(1, 1'b1, ADD, 64'd10, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, ADD, 64'd20, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, ADD, 64'd30, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, ADD, '0, '0, 1'b0, 1'b0);
        if32.out_ready = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", {63'b0, if32.out_valid}, 64'd1);
        check("mid_pre_sum", {32'b0, if32.sum}, 64'd11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'b0, if32.out_valid}, 64'd0);
        check("mid_rst_sum", {32'b0, if32.sum}, 64'd0);
        check("mid_rst_flags", {60'b0, if32.carry_out, if32.overflow, if32.zero, if32.negative}, 64'd0);
        check("mid_rst_in_ready", {63'b0, if32.in_ready}, 64'd1);
        if32.out_ready = 1'b1;
        #1 rst_n = 1'b1;
        run_op(1, "post_rst", ADD, 64'h55, 64'h11, 1'b0, 1'b0, 64'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (if32.out_valid) stale++;
            @(negedge clk);
        end
        check("no_stale_results", 64'(stale), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
